// File: rtl/rlwe_part_sequencer.sv
// Instruction sequencer in front of the RLWE processor part: accepts one
// instruction, pulses the part's active-low start line, waits for done or timeout.
module rlwe_part_sequencer #(
    parameter int unsigned GUARD   = 2,
    parameter int unsigned GAP     = 2,
    parameter logic [15:0] TIMEOUT = 16'd20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [6:0]  instr,
    output logic        rst_nc,
    output logic        rst_ac,
    output logic [1:0]  INSTRUCTION_nc,
    output logic [1:0]  NTT_ITERATION,
    output logic        add_conv,
    input  logic        part_done,
    output logic        op_done,
    output logic        op_err,
    output logic        busy,
    output logic [15:0] op_count,
    output logic [2:0]  state_dbg
);

    // Handshake: an instruction transfers on a rising edge where instr_valid
    // and instr_ready are both high; instr_ready is high only in IDLE, and
    // instr must stay stable while instr_valid is high.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [1:0]  OP_NOP     = 2'b00;
    localparam logic [1:0]  OP_NC      = 2'b01;
    localparam logic [1:0]  OP_AC      = 2'b10;
    localparam logic [15:0] GUARD_M1   = 16'(GUARD - 1);
    localparam logic [15:0] GAP_M1     = 16'(GAP - 1);
    localparam logic [15:0] TIMEOUT_M1 = TIMEOUT - 16'd1;
    localparam logic        GUARD_ZERO = (GUARD == 0);

    state_t      state_q;
    logic [1:0]  op_q;
    logic [1:0]  ins_q;
    logic [1:0]  iter_q;
    logic        conv_q;
    logic        rst_nc_q;
    logic        rst_ac_q;
    logic [15:0] cnt_q;
    logic        guard_ok_q;
    logic        op_done_q;
    logic        op_err_q;
    logic [15:0] op_count_q;

    logic        done_seen_d;
    logic        run_exit_d;
    logic        run_err_d;
    logic        is_job_d;

    // guard_ok_q opens the done input once the RUN counter has passed GUARD.
    assign done_seen_d = part_done && guard_ok_q;
    assign run_exit_d  = done_seen_d || (cnt_q == TIMEOUT_M1);
    assign run_err_d   = !done_seen_d;
    assign is_job_d    = (instr[6:5] == OP_NC) || (instr[6:5] == OP_AC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            ins_q      <= 2'd0;
            iter_q     <= 2'd0;
            conv_q     <= 1'b0;
            rst_nc_q   <= 1'b1;
            rst_ac_q   <= 1'b1;
            cnt_q      <= 16'd0;
            guard_ok_q <= 1'b0;
            op_done_q  <= 1'b0;
            op_err_q   <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            op_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q <= instr[6:5];
                        if (is_job_d) begin
                            ins_q   <= instr[4:3];
                            iter_q  <= instr[2:1];
                            conv_q  <= instr[0];
                            state_q <= S_SETUP;
                        end else begin
                            op_done_q <= 1'b1;
                            op_err_q  <= (instr[6:5] != OP_NOP);
                            state_q   <= S_FIN;
                        end
                    end
                end
                S_SETUP: begin
                    rst_nc_q   <= (op_q != OP_NC);
                    rst_ac_q   <= (op_q != OP_AC);
                    cnt_q      <= 16'd0;
                    guard_ok_q <= GUARD_ZERO;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    if (run_exit_d) begin
                        rst_nc_q  <= 1'b1;
                        rst_ac_q  <= 1'b1;
                        op_done_q <= 1'b1;
                        op_err_q  <= run_err_d;
                        if (!run_err_d) begin
                            op_count_q <= op_count_q + 16'd1;
                        end
                        cnt_q   <= 16'd0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q == GUARD_M1) begin
                            guard_ok_q <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_M1) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready    = (state_q == S_IDLE) && !rst;
    assign busy           = (state_q != S_IDLE);
    assign rst_nc         = rst_nc_q;
    assign rst_ac         = rst_ac_q;
    assign INSTRUCTION_nc = ins_q;
    assign NTT_ITERATION  = iter_q;
    assign add_conv       = conv_q;
    assign op_done        = op_done_q;
    assign op_err         = op_err_q;
    assign op_count       = op_count_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_rlwe_part_sequencer.sv
// Randomized bench for rlwe_part_sequencer: a transaction-level timing model
// predicts done cycle, error, start-line low time and job count per instruction.
module tb_rlwe_part_sequencer;

    localparam int          GUARD = 2;
    localparam int          GAP   = 2;
    localparam logic [15:0] TMO   = 16'd100;

    localparam int MODE_DELAY = 0;
    localparam int MODE_STALE = 1;
    localparam int MODE_NEVER = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [6:0]  instr;
    logic        rst_nc;
    logic        rst_ac;
    logic [1:0]  ins_o;
    logic [1:0]  iter_o;
    logic        conv_o;
    logic        part_done;
    logic        op_done;
    logic        op_err;
    logic        busy;
    logic [15:0] op_count;
    logic [2:0]  dbg;

    logic        g_valid;
    logic        g_ready;
    logic [6:0]  g_instr;
    logic        g_rst_nc;
    logic        g_rst_ac;
    logic [1:0]  g_ins;
    logic [1:0]  g_iter;
    logic        g_conv;
    logic        g_part_done;
    logic        g_op_done;
    logic        g_op_err;
    logic        g_busy;
    logic [15:0] g_op_count;
    logic [2:0]  g_dbg;

    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_count;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    rlwe_part_sequencer #(.GUARD(GUARD), .GAP(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rst_nc(rst_nc), .rst_ac(rst_ac), .INSTRUCTION_nc(ins_o),
        .NTT_ITERATION(iter_o), .add_conv(conv_o), .part_done(part_done),
        .op_done(op_done), .op_err(op_err), .busy(busy), .op_count(op_count),
        .state_dbg(dbg)
    );

    rlwe_part_sequencer #(.GUARD(0), .GAP(GAP), .TIMEOUT(TMO)) dut_g0 (
        .clk(clk), .rst(rst), .instr_valid(g_valid), .instr_ready(g_ready),
        .instr(g_instr), .rst_nc(g_rst_nc), .rst_ac(g_rst_ac), .INSTRUCTION_nc(g_ins),
        .NTT_ITERATION(g_iter), .add_conv(g_conv), .part_done(g_part_done),
        .op_done(g_op_done), .op_err(g_op_err), .busy(g_busy), .op_count(g_op_count),
        .state_dbg(g_dbg)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Timing model: all cycle numbers relative to the accept cycle T.
    task automatic model_job(input logic [6:0] v, input int mode, input int d,
                             output int done_rel, output logic err,
                             output int nc_low, output int ac_low,
                             output int ready_rel, output logic inc);
        int wait_c;
        int det_rel;
        logic [1:0] op;
        op = v[6:5];
        nc_low = 0;
        ac_low = 0;
        if (op == 2'b00 || op == 2'b11) begin
            done_rel  = 1;
            err       = (op == 2'b11);
            ready_rel = 2;
            inc       = 1'b0;
        end else begin
            wait_c = (mode == MODE_STALE) ? 0 : d;
            if (wait_c < GUARD) wait_c = GUARD;
            if (mode != MODE_NEVER && wait_c <= int'(TMO) - 1) begin
                det_rel = 2 + wait_c;
                err     = 1'b0;
            end else begin
                det_rel = 1 + int'(TMO);
                err     = 1'b1;
            end
            if (op == 2'b01) nc_low = det_rel - 1;
            else             ac_low = det_rel - 1;
            done_rel  = det_rel + 1;
            ready_rel = det_rel + 1 + GAP;
            inc       = !err;
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge where instr_ready is high; returns at the negedge
    // where instr_ready rises again, so jobs can be issued back to back.
    task automatic run_job(input string name, input logic [6:0] v, input int mode, input int d);
        int   t0, e_done, e_nc, e_ac, e_ready;
        logic e_err, e_inc;
        int   nc_low, ac_low, both, ndone, done_cyc, ready_cyc, low_seen;
        logic got_err;
        logic [4:0] got_ops;
        model_job(v, mode, d, e_done, e_err, e_nc, e_ac, e_ready, e_inc);
        t0 = cyc;
        instr = v;
        instr_valid = 1'b1;
        if (mode == MODE_STALE) part_done = 1'b1;
        nc_low = 0; ac_low = 0; both = 0; ndone = 0; low_seen = 0;
        done_cyc = -1; ready_cyc = -1; got_err = 1'b0; got_ops = 5'd0;
        for (int k = 0; k < int'(TMO) + GAP + 20 && ready_cyc < 0; k++) begin
            @(negedge clk);
            if (cyc == t0 + 1) begin
                instr_valid = 1'b0;
                check({name, "_setup_busy"}, 32'(busy), 32'd1);
                check({name, "_setup_ready"}, 32'(instr_ready), 32'd0);
                if (v[6:5] == 2'b01 || v[6:5] == 2'b10)
                    check({name, "_setup_ops"}, 32'({ins_o, iter_o, conv_o}), 32'(v[4:0]));
            end
            if (!rst_nc) nc_low++;
            if (!rst_ac) ac_low++;
            if (!rst_nc && !rst_ac) both++;
            if (!rst_nc || !rst_ac) begin
                low_seen++;
                if (mode == MODE_DELAY && low_seen == d + 1) part_done = 1'b1;
            end
            if (op_done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    got_err  = op_err;
                    got_ops  = {ins_o, iter_o, conv_o};
                end
                part_done = 1'b0;
            end else if (done_cyc >= 0 && instr_ready) begin
                ready_cyc = cyc;
            end
        end
        part_done = 1'b0;
        if (e_inc) exp_count = exp_count + 16'd1;
        check({name, "_done_cycle"}, 32'(done_cyc - t0), 32'(e_done));
        check({name, "_err"}, 32'(got_err), 32'(e_err));
        check({name, "_done_pulses"}, 32'(ndone), 32'd1);
        check({name, "_nc_low"}, 32'(nc_low), 32'(e_nc));
        check({name, "_ac_low"}, 32'(ac_low), 32'(e_ac));
        check({name, "_both_low"}, 32'(both), 32'd0);
        check({name, "_ready_cycle"}, 32'(ready_cyc - t0), 32'(e_ready));
        check({name, "_count"}, 32'(op_count), 32'(exp_count));
        if (v[6:5] == 2'b01 || v[6:5] == 2'b10)
            check({name, "_ops_held"}, 32'(got_ops), 32'(v[4:0]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, g_done;
        logic [6:0] rv;
        int r, mode, d;

        rst = 1'b1;
        instr_valid = 1'b0; instr = 7'd0; part_done = 1'b0;
        g_valid = 1'b0; g_instr = 7'd0; g_part_done = 1'b0;
        exp_count = 16'd0;
        #1;
        check("rst_rst_nc", 32'(rst_nc), 32'd1);
        check("rst_rst_ac", 32'(rst_ac), 32'd1);
        check("rst_ops", 32'({ins_o, iter_o, conv_o}), 32'd0);
        check("rst_op_done", 32'(op_done), 32'd0);
        check("rst_op_err", 32'(op_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_state", 32'(dbg), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(instr_ready), 32'd1);

        // Directed jobs
        run_job("nc50", 7'b0101101, MODE_DELAY, 49);
        run_job("stale", 7'b0110010, MODE_STALE, 0);
        run_job("ac_timeout", 7'b1000110, MODE_NEVER, 0);
        run_job("nop", 7'b0000000, MODE_DELAY, 0);
        run_job("reserved", 7'b1110101, MODE_DELAY, 0);

        // GUARD = 0 instance with a stale done: finishes at T+3
        t0 = cyc;
        g_instr = 7'b0110011;
        g_valid = 1'b1;
        g_part_done = 1'b1;
        g_done = -1;
        for (int k = 0; k < 20 && g_done < 0; k++) begin
            @(negedge clk);
            if (cyc == t0 + 1) g_valid = 1'b0;
            if (g_op_done) begin
                g_done = cyc;
                check("g0_err", 32'(g_op_err), 32'd0);
                check("g0_rst_ac", 32'(g_rst_ac), 32'd1);
                check("g0_ops", 32'({g_ins, g_iter, g_conv}), 32'(7'b0110011 & 7'h1f));
            end
        end
        g_part_done = 1'b0;
        check("g0_done_cycle", 32'(g_done - t0), 32'd3);
        check("g0_count", 32'(g_op_count), 32'd1);
        repeat (GAP + 1) @(negedge clk);
        check("g0_idle", 32'({g_ready, g_busy, g_dbg}), 32'({1'b1, 1'b0, 3'd0}));
        check("g0_nc_high", 32'(g_rst_nc), 32'd1);
        while (!instr_ready) @(negedge clk);

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            rv = 7'($urandom_range(0, 127));
            r  = $urandom_range(0, 9);
            d  = $urandom_range(0, 30);
            mode = (r == 0) ? MODE_NEVER : (r == 1) ? MODE_STALE : MODE_DELAY;
            run_job($sformatf("rand%0d", j), rv, mode, d);
        end

        // Reset in the middle of RUN
        t0 = cyc;
        instr = 7'b0100110;
        instr_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
        check("midrst_low_before", 32'(rst_nc), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_rst_nc", 32'(rst_nc), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        exp_count = 16'd0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_done", 32'(op_done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("midrst_count", 32'(op_count), 32'd0);
        run_job("after_rst", 7'b0111001, MODE_DELAY, 5);

        // Counter wrap from FFFF
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        @(negedge clk);
        exp_count = 16'hFFFF;
        check("wrap_preload", 32'(op_count), 32'hFFFF);
        run_job("wrap", 7'b1001011, MODE_DELAY, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
